prog_sequencer: RTL

Run controller that sequences the single-cycle core through one program per request. It implements a four-phase req/done handshake with the bench and selects one of NPROG program start addresses. It holds the core in reset until launch, gates PC advance, counts execution cycles, and ends the run on a halt instruction or a cycle-budget timeout. It sits between the top-level req/done pins and the PC/control datapath.

---
 rtl/prog_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - run controller: req/done handshake, program select, cycle budget
//
// Sequences the single-cycle core through one program per request.
// Ports:
//   clk_i          system clock, all state on rising edge
//   reset_ni       asynchronous active-low reset
//   req_i          four-phase run request (level)
//   prog_sel_i     program index, sampled when leaving IDLE
//   halt_i         halt-instruction decode, honoured only in RUN
//   done_o         run finished (held until req drops)
//   busy_o         high in LOAD and RUN
//   core_rst_o     holds PC at start_addr_o while high
//   core_en_o      PC advance / register-file / memory write enable
//   start_addr_o   PC load value
//   cycle_cnt_o    RUN cycles of last or current run
//   timeout_o      last run ended by budget exhaustion
//   err_o          last request had an out-of-range prog_sel
module prog_sequencer #(
    parameter int              D       = 12,
    parameter int              NPROG   = 3,
    parameter int              CW      = 16,
    parameter logic [CW-1:0]   TIMEOUT = 16'd40000,
    parameter logic [D-1:0]    START0  = 12'd0,
    parameter logic [D-1:0]    START1  = 12'd256,
    parameter logic [D-1:0]    START2  = 12'd512,
    parameter logic [D-1:0]    START3  = 12'd768
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          req_i,
    input  logic [1:0]    prog_sel_i,
    input  logic          halt_i,
    output logic          done_o,
    output logic          busy_o,
    output logic          core_rst_o,
    output logic          core_en_o,
    output logic [D-1:0]  start_addr_o,
    output logic [CW-1:0] cycle_cnt_o,
    output logic          timeout_o,
    output logic          err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0]    NPROG_W    = 3'(NPROG);
    localparam logic [CW-1:0] LAST_CYCLE = TIMEOUT - 1'b1;

    logic [1:0]    state_q, state_d;
    logic [D-1:0]  start_addr_q, start_addr_d;
    logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
    logic          timeout_q, timeout_d;
    logic          err_q, err_d;

    logic [D-1:0]  sel_addr;
    logic          sel_valid;

    always_comb begin
        sel_addr = START0;
        case (prog_sel_i)
            2'd0:    sel_addr = START0;
            2'd1:    sel_addr = START1;
            2'd2:    sel_addr = START2;
            default: sel_addr = START3;
        endcase
    end

    assign sel_valid = ({1'b0, prog_sel_i} < NPROG_W);

    // Run bookkeeping is cleared on the IDLE->LOAD edge so LOAD already
    // presents the new start address with a zeroed counter and flags.
    always_comb begin
        state_d      = state_q;
        start_addr_d = start_addr_q;
        cycle_cnt_d  = cycle_cnt_q;
        timeout_d    = timeout_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (sel_valid) begin
                        state_d      = ST_LOAD;
                        start_addr_d = sel_addr;
                        cycle_cnt_d  = '0;
                        timeout_d    = 1'b0;
                        err_d        = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cycle_cnt_d = cycle_cnt_q + 1'b1;
                // Halt has priority over the budget check in the same cycle.
                if (halt_i) begin
                    state_d = ST_DONE;
                end else if (cycle_cnt_q == LAST_CYCLE) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (!req_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= ST_IDLE;
            start_addr_q <= '0;
            cycle_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_addr_q <= start_addr_d;
            cycle_cnt_q  <= cycle_cnt_d;
            timeout_q    <= timeout_d;
            err_q        <= err_d;
        end
    end

    // Control outputs decode the registered state only.
    assign done_o       = (state_q == ST_DONE);
    assign busy_o       = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign core_rst_o   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign core_en_o    = (state_q == ST_RUN);
    assign start_addr_o = start_addr_q;
    assign cycle_cnt_o  = cycle_cnt_q;
    assign timeout_o    = timeout_q;
    assign err_o        = err_q;

endmodule
